// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared loader state encoding and width defaults.
package im_loader_pkg;
    localparam int IW_DEF = 15;
    localparam int AW_DEF = 8;
    localparam int BW = 8;
    typedef enum logic [2:0] {IDLE, LO, HI, CHK, RUN, ERR} state_t;
endpackage

// File: rtl/im_loader_xsum.sv
// im_loader_xsum: 8-bit running XOR accumulator with clear and enable.
module im_loader_xsum
    import im_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [BW-1:0] d,
    output logic [BW-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= q ^ d;
endmodule

// File: rtl/im_loader.sv
// im_loader: streams LEN, N lo/hi word pairs and CHK into IM, holding the CPU until done.
// Define IM_LOADER_CHECKSUM_EN to verify CHK against an XOR of LEN and data bytes.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reload,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    state_t state, state_nx;
    logic [BW-1:0] cnt, lo;
    logic xfer, chk_ok;

    always_comb begin
        in_ready = !rst && (state inside {IDLE, LO, HI, CHK});
        xfer = in_valid && in_ready;
        state_nx = state;
        case (state)
            IDLE: if (xfer) state_nx = (in_data == '0) ? CHK : LO;
            LO:   if (xfer) state_nx = HI;
            HI:   if (xfer) state_nx = (cnt == 8'd1) ? CHK : LO;
            CHK:  if (xfer) state_nx = chk_ok ? RUN : ERR;
            RUN, ERR: if (reload) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // The write is registered so addr/data stay stable for the whole im_we cycle.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            lo <= '0;
            im_we <= 1'b0;
            im_addr <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= xfer && state == HI;
            if (im_we) im_addr <= im_addr + 1'b1;
            if (reload && state inside {RUN, ERR}) im_addr <= '0;
            if (xfer && state == IDLE) cnt <= in_data;
            if (xfer && state == HI) cnt <= cnt - 8'd1;
            if (xfer && state == LO) lo <= in_data;
            if (xfer && state == HI) im_wdata <= {in_data[IW-9:0], lo};
        end

`ifdef IM_LOADER_CHECKSUM_EN
    logic [BW-1:0] xsum;
    im_loader_xsum u_xsum (
        .clk (clk),
        .rst (rst),
        .clr (reload && state inside {RUN, ERR}),
        .en  (xfer && state inside {IDLE, LO, HI}),
        .d   (in_data),
        .q   (xsum)
    );
    assign chk_ok = in_data == xsum;
    assign err = state == ERR;
`else
    assign chk_ok = 1'b1;
    assign err = 1'b0;
`endif

    assign done = state == RUN;
    assign cpu_hold = state != RUN;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed-vector bench for im_loader with hand-computed expectations.
module tb_im_loader;
`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk, rst, in_valid, in_ready, reload, im_we, cpu_hold, done, err;
    logic [7:0] in_data, im_addr;
    logic [14:0] im_wdata;
    logic [7:0] wa[$];
    logic [14:0] wd[$];
    int checks = 0, errors = 0;

    im_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reload(reload), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            return;
        end
        in_data = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic img(input logic [7:0] chk, input int gap);
        logic [7:0] v[5] = '{8'h02, 8'h2A, 8'h00, 8'h7B, 8'h01};
        foreach (v[i]) send(v[i], gap);
        check("hold_before_chk", cpu_hold, 1);
        send(chk, gap);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("rl_done", done, 0);
        check("rl_err", err, 0);
        check("rl_hold", cpu_hold, 1);
        check("rl_addr", im_addr, 0);
        wa.delete();
        wd.delete();
    endtask

    task automatic check_img(input string tag);
        check({tag, "_nw"}, wa.size(), 2);
        check({tag, "_a0"}, wa[0], 0);
        check({tag, "_d0"}, wd[0], 15'h002A);
        check({tag, "_a1"}, wa[1], 1);
        check({tag, "_d1"}, wd[1], 15'h017B);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        reload = 1'b0;
        repeat (2) tick();
        check("rst_ready", in_ready, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", im_we, 0);
        check("rst_addr", im_addr, 0);
        check("rst_wdata", im_wdata, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", in_ready, 1);

        img(8'h52, 0);
        check_img("valid");
        check("valid_done", done, 1);
        check("valid_hold", cpu_hold, 0);
        check("valid_ready", in_ready, 0);
        check("valid_err", err, 0);
        check("valid_addr", im_addr, 2);

        do_reload();
        img(8'h53, 0);
        check_img("bad");
        check("bad_err", err, CK);
        check("bad_hold", cpu_hold, CK);
        check("bad_done", done, !CK);
        do_reload();
        img(8'h52, 0);
        check("resend_done", done, 1);
        check("resend_err", err, 0);

        do_reload();
        send(8'h00, 0);
        send(8'h00, 0);
        repeat (2) tick();
        check("empty_nw", wa.size(), 0);
        check("empty_done", done, 1);
        check("empty_hold", cpu_hold, 0);

        do_reload();
        img(8'h52, 3);
        check_img("stall");
        check("stall_done", done, 1);

        do_reload();
        send(8'h03, 0);
        send(8'h05, 0);
        send(8'h06, 0);
        rst = 1'b1;
        #1;
        check("midrst_hold", cpu_hold, 1);
        check("midrst_addr", im_addr, 0);
        check("midrst_we", im_we, 0);
        tick();
        rst = 1'b0;
        wa.delete();
        wd.delete();
        tick();
        send(8'h01, 0);
        send(8'h05, 0);
        send(8'h00, 0);
        send(8'h04, 0);
        check("midrst_nw", wa.size(), 1);
        check("midrst_a0", wa[0], 0);
        check("midrst_d0", wd[0], 15'h0005);
        check("midrst_done", done, 1);

        do_reload();
        send(8'h01, 0);
        send(8'hFF, 0);
        send(8'hFF, 0);
        send(8'h01, 0);
        check("mask_d0", wd[0], 15'h7FFF);
        check("mask_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
